default_chan_tx_scheduler: RTL and testbench



---
 rtl/default_chan_tx_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_default_chan_tx_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/default_chan_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : default_chan_tx_scheduler
// Description : Timed-burst scheduler for the channel transmit path. Queues
//               burst descriptors (start time, length), holds the sample
//               stream until the shared sample counter reaches the start
//               time, then passes exactly 'length' samples downstream.
//               Late bursts are dropped or sent at once; mid-burst
//               starvation is flagged per cycle.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               cfg_enabled           - 0 flushes FIFO and returns to IDLE
//               cfg_late_policy       - 0 drop late burst, 1 send it at once
//               sample_idx[55:0]      - free-running DAC sample counter
//               desc_*                - descriptor push handshake
//               s_*                   - upstream sample stream
//               m_*                   - downstream sample stream
//               tx_active             - high while in RUN
//               desc_count            - descriptor FIFO occupancy
//               status_late           - pulse when a late burst is found
//               status_starved        - pulse per starved RUN cycle
//               status_late_count     - saturating late-burst counter
// Revision    : 1.0 - initial release
// ============================================================================
module default_chan_tx_scheduler #(
  parameter int DEPTH_LOG2 = 2,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_enabled,
  input  logic                  cfg_late_policy,
  input  logic [55:0]           sample_idx,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [55:0]           desc_time,
  input  logic [LEN_W-1:0]      desc_len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [63:0]           s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [63:0]           m_data,
  output logic                  tx_active,
  output logic [DEPTH_LOG2:0]   desc_count,
  output logic                  status_late,
  output logic                  status_starved,
  output logic [15:0]           status_late_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]      LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t                 state;
  logic [55:0]            fifo_time [DEPTH];
  logic [LEN_W-1:0]       fifo_len  [DEPTH];
  logic [DEPTH_LOG2-1:0]  wr_ptr;
  logic [DEPTH_LOG2-1:0]  rd_ptr;
  logic [DEPTH_LOG2:0]    count;
  logic [55:0]            act_time;
  logic [LEN_W-1:0]       act_len;
  logic [LEN_W-1:0]       sent;
  logic                   first_wait;
  logic                   late_pulse;
  logic                   starved_pulse;
  logic [15:0]            late_count;

  logic                   push;
  logic                   pop;
  logic                   run_on;
  logic                   drop_on;
  logic                   beat;
  logic                   last;
  logic [55:0]            diff;

  always_comb begin
    push    = desc_valid && desc_ready;
    pop     = cfg_enabled && (state == IDLE) && (count != '0);
    // Gating with cfg_enabled keeps samples upstream during an abort cycle.
    run_on  = cfg_enabled && (state == RUN);
    drop_on = cfg_enabled && (state == DROP);
    // One sample leaves the upstream port: a downstream handshake in RUN,
    // or a silent consume in DROP.
    beat    = (run_on && s_valid && m_ready) || (drop_on && s_valid);
    last    = (sent == (act_len - LEN_ONE));
    // Modular difference: zero means due, MSB set means already passed.
    diff    = act_time - sample_idx;
  end

  assign desc_ready        = cfg_enabled && (count != FULL_LEVEL);
  assign desc_count        = count;
  assign m_valid           = run_on && s_valid;
  assign s_ready           = (run_on && m_ready) || drop_on;
  assign m_data            = run_on ? s_data : 64'd0;
  assign tx_active         = (state == RUN);
  assign status_late       = late_pulse;
  assign status_starved    = starved_pulse;
  assign status_late_count = late_count;

  // Descriptor storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_time[wr_ptr] <= desc_time;
      fifo_len[wr_ptr]  <= desc_len;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      act_time      <= '0;
      act_len       <= '0;
      sent          <= '0;
      first_wait    <= 1'b0;
      late_pulse    <= 1'b0;
      starved_pulse <= 1'b0;
      late_count    <= '0;
    end else begin
      late_pulse    <= 1'b0;
      starved_pulse <= run_on && m_ready && !s_valid;
      if (!cfg_enabled) begin
        // Abort: flush everything except the status counter.
        state      <= IDLE;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        sent       <= '0;
        first_wait <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        case ({push, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase

        case (state)
          IDLE: begin
            if (pop) begin
              act_time   <= fifo_time[rd_ptr];
              act_len    <= fifo_len[rd_ptr];
              sent       <= '0;
              first_wait <= 1'b1;
              // Null descriptors are consumed here and never leave IDLE.
              if (fifo_len[rd_ptr] != '0) state <= WAIT;
            end
          end
          WAIT: begin
            first_wait <= 1'b0;
            if (first_wait && diff[55]) begin
              late_pulse <= 1'b1;
              if (late_count != 16'hFFFF) late_count <= late_count + 16'd1;
              state <= cfg_late_policy ? RUN : DROP;
            end else if (diff == '0) begin
              state <= RUN;
            end
          end
          RUN, DROP: begin
            if (beat) begin
              if (last) begin
                state <= IDLE;
                sent  <= '0;
              end else begin
                sent  <= sent + LEN_ONE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_default_chan_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_default_chan_tx_scheduler
// Description : Self-checking bench for default_chan_tx_scheduler. Timed
//               burst vectors from a table, plus hand-written sequences for
//               backpressure/starvation, FIFO full with a null descriptor,
//               abort and counter wrap. Output samples are checked against a
//               scoreboard queue filled when each burst is set up.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_default_chan_tx_scheduler;

  localparam logic [63:0] BASE = 64'hC0DE_0000_0000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_enabled;
  logic         cfg_late_policy;
  logic [55:0]  sample_idx;
  logic         desc_valid;
  logic         desc_ready;
  logic [55:0]  desc_time;
  logic [15:0]  desc_len;
  logic         s_valid;
  logic         s_ready;
  logic [63:0]  s_data;
  logic         m_valid;
  logic         m_ready;
  logic [63:0]  m_data;
  logic         tx_active;
  logic [2:0]   desc_count;
  logic         status_late;
  logic         status_starved;
  logic [15:0]  status_late_count;

  always #5 clk = ~clk;

  default_chan_tx_scheduler #(.DEPTH_LOG2(2), .LEN_W(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .cfg_enabled       (cfg_enabled),
    .cfg_late_policy   (cfg_late_policy),
    .sample_idx        (sample_idx),
    .desc_valid        (desc_valid),
    .desc_ready        (desc_ready),
    .desc_time         (desc_time),
    .desc_len          (desc_len),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_data            (m_data),
    .tx_active         (tx_active),
    .desc_count        (desc_count),
    .status_late       (status_late),
    .status_starved    (status_starved),
    .status_late_count (status_late_count)
  );

  int checks = 0;
  int passed = 0;

  logic [63:0] exp_q[$];
  logic [55:0] start_q[$];
  int          src = 0;
  int          hs, cons, late_p, starv, txw, accepted;
  bit          first_seen;
  bit          prev_mv = 1'b0;
  logic [55:0] first_idx;
  int          exp_late = 0;

  typedef struct {
    logic [55:0] start;
    logic [55:0] t;
    logic [15:0] len;
    bit          pol;
    bit          late;
    int          hs;
    logic [55:0] first;
  } vec_t;
  vec_t vecs[5];

  bit pm[16] = '{1,0,1,0,1,1,1,1,1,1,1,1,1,1,1,1};
  bit ps[16] = '{1,1,1,1,0,0,0,1,1,1,1,1,1,1,1,1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic clear_counters();
    hs = 0; cons = 0; late_p = 0; starv = 0; txw = 0;
    first_seen = 1'b0; first_idx = '0;
    start_q.delete();
  endtask

  // One clock: observe at the falling edge, then advance inputs just after
  // the rising edge.
  task automatic cyc();
    @(negedge clk);
    if (m_valid) begin
      if (!first_seen) begin
        first_seen = 1'b1;
        first_idx  = sample_idx;
      end
      if (!prev_mv) start_q.push_back(sample_idx);
    end
    prev_mv = m_valid;
    if (m_valid && m_ready) begin
      hs++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL sb_unexpected_out: got data %0h, required no handshake", m_data);
      end else begin
        check("sb_data", m_data, exp_q.pop_front());
      end
    end
    if (s_valid && s_ready) begin
      src++;
      cons++;
    end
    if (status_late)    late_p++;
    if (status_starved) starv++;
    if (tx_active)      txw++;
    if (desc_valid && desc_ready) accepted++;
    @(posedge clk);
    #1;
    sample_idx = sample_idx + 56'd1;
    s_data     = BASE + 64'(src);
  endtask

  task automatic push_desc(input logic [55:0] t, input logic [15:0] len);
    int acc0;
    acc0       = accepted;
    desc_time  = t;
    desc_len   = len;
    desc_valid = 1'b1;
    for (int i = 0; i < 50 && accepted == acc0; i++) cyc();
    desc_valid = 1'b0;
    if (accepted == acc0) begin
      checks++;
      $display("FAIL desc_push_timeout: got no handshake, required one");
    end
  endtask

  task automatic push_expected(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(BASE + 64'(src + k));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    logic [55:0] p;
    logic [55:0] exp_starts[4];

    reset = 1'b1; cfg_enabled = 1'b0; cfg_late_policy = 1'b0;
    sample_idx = '0; desc_valid = 1'b0; desc_time = '0; desc_len = '0;
    s_valid = 1'b0; m_ready = 1'b0; s_data = BASE;
    accepted = 0;
    clear_counters();

    vecs[0] = '{start: 56'd90,  t: 56'd100, len: 16'd4, pol: 1'b0, late: 1'b0, hs: 4, first: 56'd101};
    vecs[1] = '{start: 56'd80,  t: 56'd50,  len: 16'd4, pol: 1'b0, late: 1'b1, hs: 0, first: 56'd0};
    vecs[2] = '{start: 56'd80,  t: 56'd50,  len: 16'd4, pol: 1'b1, late: 1'b1, hs: 4, first: 56'd83};
    vecs[3] = '{start: 56'd200, t: 56'd202, len: 16'd3, pol: 1'b0, late: 1'b0, hs: 3, first: 56'd203};
    vecs[4] = '{start: 56'd300, t: 56'd302 + (56'd1 << 55), len: 16'd2, pol: 1'b1, late: 1'b1, hs: 2, first: 56'd303};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_m_valid", m_valid, 0);
    check("reset_s_ready", s_ready, 0);
    check("reset_tx_active", tx_active, 0);
    check("reset_desc_count", desc_count, 0);
    check("reset_status", {status_late, status_starved, status_late_count}, 0);
    check("reset_m_data", m_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b0; cfg_enabled = 1'b1;
    #1;
    check("desc_ready_enabled", desc_ready, 1);

    // Table-driven timed bursts
    for (int v = 0; v < 5; v++) begin
      clear_counters();
      cfg_late_policy = vecs[v].pol;
      sample_idx      = vecs[v].start;
      s_valid         = 1'b1;
      m_ready         = 1'b1;
      push_expected(vecs[v].hs);
      push_desc(vecs[v].t, vecs[v].len);
      repeat (30) cyc();
      exp_late += int'(vecs[v].late);
      check($sformatf("v%0d_late_pulses", v), late_p, int'(vecs[v].late));
      check($sformatf("v%0d_late_count", v), status_late_count, exp_late);
      check($sformatf("v%0d_handshakes", v), hs, vecs[v].hs);
      check($sformatf("v%0d_consumed", v), cons, vecs[v].len);
      check($sformatf("v%0d_tx_width", v), txw, vecs[v].hs);
      check($sformatf("v%0d_sb_empty", v), exp_q.size(), 0);
      if (vecs[v].hs > 0) check($sformatf("v%0d_first_idx", v), first_idx, vecs[v].first);
    end

    // Backpressure and starvation
    clear_counters();
    cfg_late_policy = 1'b0;
    push_expected(8);
    push_desc(sample_idx + 56'd3, 16'd8);
    for (int i = 0; i < 20 && !tx_active; i++) cyc();
    check("bp_tx_started", tx_active, 1);
    for (int k = 0; k < 16; k++) begin
      m_ready = pm[k];
      s_valid = ps[k];
      cyc();
    end
    m_ready = 1'b1; s_valid = 1'b1;
    repeat (4) cyc();
    check("bp_starved_pulses", starv, 3);
    check("bp_handshakes", hs, 8);
    check("bp_sb_empty", exp_q.size(), 0);

    // FIFO full and null descriptor
    clear_counters();
    p = sample_idx;
    push_expected(8);
    push_desc(p + 56'd20, 16'd2);
    push_desc(p + 56'd22, 16'd0);
    push_desc(p + 56'd30, 16'd3);
    push_desc(p + 56'd40, 16'd1);
    push_desc(p + 56'd50, 16'd2);
    check("full_desc_count", desc_count, 4);
    check("full_desc_ready", desc_ready, 0);
    repeat (70) cyc();
    exp_starts[0] = p + 56'd21;
    exp_starts[1] = p + 56'd31;
    exp_starts[2] = p + 56'd41;
    exp_starts[3] = p + 56'd51;
    check("full_burst_count", start_q.size(), 4);
    for (int k = 0; k < 4; k++)
      if (k < start_q.size()) check($sformatf("full_start%0d", k), start_q[k], exp_starts[k]);
    check("full_handshakes", hs, 8);
    check("full_sb_empty", exp_q.size(), 0);
    check("full_no_late", late_p, 0);

    // Abort mid-RUN
    clear_counters();
    push_expected(10);
    push_desc(sample_idx + 56'd3, 16'd10);
    for (int i = 0; i < 20 && !tx_active; i++) cyc();
    push_desc(sample_idx + 56'd1000, 16'd5);
    cyc();
    check("abort_pre_count", desc_count, 1);
    cfg_enabled = 1'b0;
    cyc();
    check("abort_tx_active", tx_active, 0);
    check("abort_desc_count", desc_count, 0);
    check("abort_s_ready", s_ready, 0);
    check("abort_m_valid", m_valid, 0);
    check("abort_handshakes", hs, 2);
    check("abort_consumed", cons, 2);
    check("abort_late_kept", status_late_count, exp_late);
    exp_q.delete();

    // Counter wrap
    cfg_enabled = 1'b1;
    clear_counters();
    sample_idx = {56{1'b1}} - 56'd1;
    push_expected(3);
    push_desc(56'd1, 16'd3);
    repeat (12) cyc();
    check("wrap_first_idx", first_idx, 56'd2);
    check("wrap_handshakes", hs, 3);
    check("wrap_not_late", late_p, 0);
    check("wrap_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
